// File: rtl/bcd_disp_mux_pkg.sv
// ---------------------------------------------------------------------------
// bcd_disp_mux_pkg
// Shared constants for seven-segment display drivers.
//   SEG_0..SEG_9 : active-low {a,b,c,d,e,f,g} patterns for decimal digits
//   SEG_DASH     : middle bar only, shown for codes 10..15
//   SEG_BLANK    : all segments off
//   AN_OFF       : all anodes off (active-low anode enables)
//   SSEG_OFF     : all segments and the decimal point off
// ---------------------------------------------------------------------------
package bcd_disp_mux_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF    = 4'b1111;
    localparam logic [7:0] SSEG_OFF  = 8'hFF;

endpackage

// File: rtl/bcd_disp_mux_if.sv
// ---------------------------------------------------------------------------
// bcd_disp_mux_if
// Bundles the capture inputs and the display outputs of bcd_disp_mux.
//   load        : capture strobe (converter done_tick)
//   bcd3..bcd0  : BCD digits, bcd3 most significant
//   dp_in       : decimal point enables, bit k = digit k, active high
//   an          : anode enables, active low
//   sseg        : segments, active low, sseg[7] = dp
//   valid       : a value has been captured since reset
// master = the side supplying digits and watching the display,
// slave  = the display multiplexer itself.
// ---------------------------------------------------------------------------
interface bcd_disp_mux_if;
    import bcd_disp_mux_pkg::*;

    logic       load;
    logic [3:0] bcd3;
    logic [3:0] bcd2;
    logic [3:0] bcd1;
    logic [3:0] bcd0;
    logic [3:0] dp_in;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       valid;

    modport master (
        output load, bcd3, bcd2, bcd1, bcd0, dp_in,
        input  an, sseg, valid
    );

    modport slave (
        input  load, bcd3, bcd2, bcd1, bcd0, dp_in,
        output an, sseg, valid
    );

endinterface

// File: rtl/bcd_disp_mux_to_sseg.sv
// ---------------------------------------------------------------------------
// bcd_to_sseg
// Combinational decoder from a 4-bit code to an active-low 7-segment pattern.
//   i_code  : 4-bit code; 0..9 decode to digits, 10..15 to a dash
//   i_blank : forces all segments off regardless of the code
//   o_seg   : active-low {a,b,c,d,e,f,g}
// ---------------------------------------------------------------------------
module bcd_to_sseg
    import bcd_disp_mux_pkg::*;
(
    input  logic [3:0] i_code,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    // Blank wins over the code; anything outside 0..9 falls through to the dash.
    always_comb begin
        o_seg = SEG_DASH;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else begin
            case (i_code)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_disp_mux.sv
// ---------------------------------------------------------------------------
// bcd_disp_mux
// Captures four BCD digits on a load strobe and scans them onto a
// common-anode 4-digit 7-segment display with leading-zero blanking,
// per-digit decimal points, a dash for invalid codes and an anode dead-time
// at the start of every digit slot.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : slave side of bcd_disp_mux_if (load/bcd3..0/dp_in in,
//           an/sseg/valid out)
// Parameters:
//   N        : refresh counter width, one full scan = 2^N cycles
//   DEAD     : cycles at the start of each slot with all anodes off
//   BLANK_LZ : 1 = blank leading zeros, 0 = show all four digits
// ---------------------------------------------------------------------------
module bcd_disp_mux
    import bcd_disp_mux_pkg::*;
#(
    parameter int N        = 18,
    parameter int DEAD     = 8,
    parameter int BLANK_LZ = 1
)
(
    input  logic            clk,
    input  logic            reset,
    bcd_disp_mux_if.slave   bus
);

    localparam int OW = N - 2;

    logic [3:0]   r_digit [4];
    logic [3:0]   r_dp;
    logic         r_valid;
    logic [N-1:0] r_q;
    logic [3:0]   r_an;
    logic [7:0]   r_sseg;

    logic [1:0]    w_sel;
    logic [OW-1:0] w_off;
    logic [3:0]    w_blank;
    logic          w_dead;
    logic [6:0]    w_seg;

    assign w_sel = r_q[N-1:N-2];
    assign w_off = r_q[OW-1:0];

    // Capture registers: a load overwrites all digits and decimal points at
    // once, so back-to-back loads simply keep the most recent value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_digit[i] <= 4'd0;
            end
            r_dp    <= 4'b0000;
            r_valid <= 1'b0;
        end else if (bus.load) begin
            r_digit[3] <= bus.bcd3;
            r_digit[2] <= bus.bcd2;
            r_digit[1] <= bus.bcd1;
            r_digit[0] <= bus.bcd0;
            r_dp       <= bus.dp_in;
            r_valid    <= 1'b1;
        end
    end

    // Free-running refresh counter; loads never restart the scan.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_q + 1'b1;
        end
    end

    // A digit is a leading zero only when it and every more significant
    // digit are exactly zero; codes 10..15 count as non-zero. Digit 0 always
    // shows so that a zero value still lights one digit.
    generate
        if (BLANK_LZ != 0) begin : g_blank
            logic w_z3, w_z2, w_z1;
            assign w_z3    = (r_digit[3] == 4'd0);
            assign w_z2    = (r_digit[2] == 4'd0);
            assign w_z1    = (r_digit[1] == 4'd0);
            assign w_blank = {w_z3, w_z3 & w_z2, w_z3 & w_z2 & w_z1, 1'b0};
        end else begin : g_noblank
            assign w_blank = 4'b0000;
        end
    endgenerate

    // Dead-time window at the start of each slot; with DEAD = 0 there is no
    // window at all, which is handled separately to avoid a compare against 0.
    generate
        if (DEAD == 0) begin : g_nodead
            assign w_dead = 1'b0;
        end else begin : g_dead
            assign w_dead = (w_off < OW'(DEAD));
        end
    endgenerate

    bcd_to_sseg u_dec (
        .i_code  (r_digit[w_sel]),
        .i_blank (w_blank[w_sel]),
        .o_seg   (w_seg)
    );

    // Registered display outputs, derived from the current counter and
    // capture registers, so a capture shows up one edge after it happens.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an   <= AN_OFF;
            r_sseg <= SSEG_OFF;
        end else if (!r_valid || w_dead) begin
            r_an   <= AN_OFF;
            r_sseg <= SSEG_OFF;
        end else begin
            r_an   <= ~(4'b0001 << w_sel);
            r_sseg <= {~r_dp[w_sel], w_seg};
        end
    end

    assign bus.an    = r_an;
    assign bus.sseg  = r_sseg;
    assign bus.valid = r_valid;

endmodule

// File: tb/tb_bcd_disp_mux.sv
// ---------------------------------------------------------------------------
// tb_bcd_disp_mux
// Directed bench for bcd_disp_mux with N=4 (slot = 4 cycles, scan = 16).
// Three instances share the same stimulus:
//   dutMain   : DEAD=1, BLANK_LZ=1
//   dutNoLz   : DEAD=1, BLANK_LZ=0
//   dutNoDead : DEAD=0, BLANK_LZ=1
// ---------------------------------------------------------------------------
module tb_bcd_disp_mux;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bcd_disp_mux_if busMain ();
    bcd_disp_mux_if busNoLz ();
    bcd_disp_mux_if busNoDead ();

    bcd_disp_mux #(.N(4), .DEAD(1), .BLANK_LZ(1)) dutMain (
        .clk   (clk),
        .reset (reset),
        .bus   (busMain)
    );

    bcd_disp_mux #(.N(4), .DEAD(1), .BLANK_LZ(0)) dutNoLz (
        .clk   (clk),
        .reset (reset),
        .bus   (busNoLz)
    );

    bcd_disp_mux #(.N(4), .DEAD(0), .BLANK_LZ(1)) dutNoDead (
        .clk   (clk),
        .reset (reset),
        .bus   (busNoDead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed slot patterns for the value 1,2,3,4 with dp_in = 4'b0100.
    logic [3:0] anTab   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] segTab  [4] = '{8'hCC, 8'h86, 8'h12, 8'hCF};

    // One clock: advance past the active edge, then return at the falling
    // edge so outputs are sampled away from the posedge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Scan position the outputs currently reflect (one cycle behind q).
    function automatic int outQ();
        return (cyc - 1) % 16;
    endfunction

    task automatic checkOutput(input string tag,
                               input logic [3:0] obsAn,  input logic [7:0] obsSseg,
                               input logic [3:0] expAn,  input logic [7:0] expSseg);
        checks++;
        assert ({obsAn, obsSseg} === {expAn, expSseg})
        else begin
            errors++;
            $error("[TB] FAIL %s: an=%b sseg=%h, expected an=%b sseg=%h",
                   tag, obsAn, obsSseg, expAn, expSseg);
        end
    endtask

    task automatic checkValid(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: valid=%b, expected %b", tag, obs, exp);
        end
    endtask

    // Advance until the outputs reflect scan position q; bounded.
    task automatic stepTo(input int q);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (outQ() == q) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        assert (hit)
        else begin
            errors++;
            $error("[TB] FAIL stepTo: position %0d not reached, expected within 40 cycles", q);
        end
    endtask

    // Drive one load cycle into all three instances.
    task automatic applyStimulus(input logic [3:0] d3, input logic [3:0] d2,
                                 input logic [3:0] d1, input logic [3:0] d0,
                                 input logic [3:0] dp);
        busMain.bcd3 = d3;   busMain.bcd2 = d2;   busMain.bcd1 = d1;   busMain.bcd0 = d0;
        busNoLz.bcd3 = d3;   busNoLz.bcd2 = d2;   busNoLz.bcd1 = d1;   busNoLz.bcd0 = d0;
        busNoDead.bcd3 = d3; busNoDead.bcd2 = d2; busNoDead.bcd1 = d1; busNoDead.bcd0 = d0;
        busMain.dp_in = dp;  busNoLz.dp_in = dp;  busNoDead.dp_in = dp;
        busMain.load = 1'b1; busNoLz.load = 1'b1; busNoDead.load = 1'b1;
        tick();
        busMain.load = 1'b0; busNoLz.load = 1'b0; busNoDead.load = 1'b0;
    endtask

    initial begin
        int q;
        reset = 1'b0;
        busMain.load = 1'b0;   busNoLz.load = 1'b0;   busNoDead.load = 1'b0;
        busMain.bcd3 = 4'd0;   busMain.bcd2 = 4'd0;   busMain.bcd1 = 4'd0;   busMain.bcd0 = 4'd0;
        busNoLz.bcd3 = 4'd0;   busNoLz.bcd2 = 4'd0;   busNoLz.bcd1 = 4'd0;   busNoLz.bcd0 = 4'd0;
        busNoDead.bcd3 = 4'd0; busNoDead.bcd2 = 4'd0; busNoDead.bcd1 = 4'd0; busNoDead.bcd0 = 4'd0;
        busMain.dp_in = 4'd0;  busNoLz.dp_in = 4'd0;  busNoDead.dp_in = 4'd0;

        // Reset, then idle with no load: display stays dark.
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset", busMain.an, busMain.sseg, 4'b1111, 8'hFF);
        checkValid("reset_valid", busMain.valid, 1'b0);
        reset = 1'b0;
        cyc   = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            checkOutput("idle", busMain.an, busMain.sseg, 4'b1111, 8'hFF);
            checkValid("idle_valid", busMain.valid, 1'b0);
        end

        // Back-to-back loads: the second value must win.
        applyStimulus(4'd9, 4'd9, 4'd9, 4'd9, 4'b1111);
        applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'b0100);
        checkValid("load_valid", busMain.valid, 1'b1);
        checkValid("load_valid_nolz", busNoLz.valid, 1'b1);
        stepTo(1);  checkOutput("v1234_d0",   busMain.an, busMain.sseg, 4'b1110, 8'hCC);
        stepTo(4);  checkOutput("v1234_dead1", busMain.an, busMain.sseg, 4'b1111, 8'hFF);
        stepTo(5);  checkOutput("v1234_d1",   busMain.an, busMain.sseg, 4'b1101, 8'h86);
        stepTo(8);  checkOutput("v1234_dead2", busMain.an, busMain.sseg, 4'b1111, 8'hFF);
        stepTo(9);  checkOutput("v1234_d2",   busMain.an, busMain.sseg, 4'b1011, 8'h12);
        stepTo(13); checkOutput("v1234_d3",   busMain.an, busMain.sseg, 4'b0111, 8'hCF);
        stepTo(0);  checkOutput("v1234_dead0", busMain.an, busMain.sseg, 4'b1111, 8'hFF);

        // Leading-zero blanking on 0007.
        applyStimulus(4'd0, 4'd0, 4'd0, 4'd7, 4'b0000);
        stepTo(13); checkOutput("v0007_d3",      busMain.an, busMain.sseg, 4'b0111, 8'hFF);
                    checkOutput("v0007_d3_nolz", busNoLz.an, busNoLz.sseg, 4'b0111, 8'h81);
        stepTo(9);  checkOutput("v0007_d2",      busMain.an, busMain.sseg, 4'b1011, 8'hFF);
        stepTo(5);  checkOutput("v0007_d1",      busMain.an, busMain.sseg, 4'b1101, 8'hFF);
        stepTo(1);  checkOutput("v0007_d0",      busMain.an, busMain.sseg, 4'b1110, 8'h8F);

        // All zeros: only digit 0 lit; then dp survives on a blanked digit.
        applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
        stepTo(13); checkOutput("v0000_d3",      busMain.an, busMain.sseg, 4'b0111, 8'hFF);
                    checkOutput("v0000_d3_nolz", busNoLz.an, busNoLz.sseg, 4'b0111, 8'h81);
        stepTo(1);  checkOutput("v0000_d0",      busMain.an, busMain.sseg, 4'b1110, 8'h81);
        applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 4'b1000);
        stepTo(13); checkOutput("v0000_dp3",     busMain.an, busMain.sseg, 4'b0111, 8'h7F);

        // Invalid code 0xC counts as non-zero and shows a dash.
        applyStimulus(4'd0, 4'd0, 4'hC, 4'd5, 4'b0000);
        stepTo(5);  checkOutput("v00C5_d1", busMain.an, busMain.sseg, 4'b1101, 8'hFE);
        stepTo(9);  checkOutput("v00C5_d2", busMain.an, busMain.sseg, 4'b1011, 8'hFF);
        stepTo(13); checkOutput("v00C5_d3", busMain.an, busMain.sseg, 4'b0111, 8'hFF);
        stepTo(1);  checkOutput("v00C5_d0", busMain.an, busMain.sseg, 4'b1110, 8'hA4);

        // Mid-slot load: old value on the capture edge, new value one edge later.
        applyStimulus(4'd9, 4'd8, 4'd7, 4'd6, 4'b0001);
        checkOutput("midload_edge", busMain.an, busMain.sseg, 4'b1110, 8'hA4);
        tick();
        checkOutput("midload_next", busMain.an, busMain.sseg, 4'b1110, 8'h20);

        // Asynchronous reset mid-scan, observed before any clock edge.
        reset = 1'b1;
        #1;
        checkOutput("async_reset", busMain.an, busMain.sseg, 4'b1111, 8'hFF);
        checkValid("async_reset_valid", busMain.valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;

        // Free run past one full scan: slot order 0,1,2,3 then back to 0.
        applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'b0100);
        for (int i = 0; i < 24; i++) begin
            tick();
            q = outQ();
            if ((q % 4) == 0)
                checkOutput("freerun", busMain.an, busMain.sseg, 4'b1111, 8'hFF);
            else
                checkOutput("freerun", busMain.an, busMain.sseg, anTab[q / 4], segTab[q / 4]);
            checkOutput("freerun_nodead", busNoDead.an, busNoDead.sseg, anTab[q / 4], segTab[q / 4]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
